// File: rtl/pc_unit.sv
// Instruction-fetch program counter with reset vector, configurable step, stall,
// branch redirect and an optional return-address stack enabled by PC_RAS_EN.
module pc_unit #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned INC        = 1,
  parameter int unsigned RAS_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branch_en,
  input  logic [ADDR_WIDTH-1:0]            branch_target,
  input  logic                             call_en,
  input  logic                             ret_en,
  output logic [ADDR_WIDTH-1:0]            pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_depth,
  output logic                             ras_ovf,
  output logic                             ras_unf
);

  localparam int DW = $clog2(RAS_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] RST_PC = ADDR_WIDTH'(RESET_ADDR);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(INC);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;
  logic [ADDR_WIDTH-1:0] seq_pc;

  assign seq_pc = pc_q + STEP;
  assign pc_out = pc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RST_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_RAS_EN

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [DW-1:0] FULL = DW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]         top_q;
  logic [PW-1:0]         top_d;
  logic [PW-1:0]         top_inc;
  logic [PW-1:0]         top_dec;
  logic [DW-1:0]         depth_q;
  logic [DW-1:0]         depth_d;
  logic                  ovf_q;
  logic                  ovf_d;
  logic                  unf_q;
  logic                  unf_d;
  logic                  wr_en;
  logic [PW-1:0]         wr_idx;
  logic                  ras_empty;
  logic                  ras_full;

  // Circular buffer: a push when full lands on the oldest slot, discarding it.
  assign top_inc   = (top_q == LAST) ? '0 : top_q + PW'(1);
  assign top_dec   = (top_q == '0) ? LAST : top_q - PW'(1);
  assign ras_empty = (depth_q == '0);
  assign ras_full  = (depth_q == FULL);

  always_comb begin
    pc_d    = pc_q;
    top_d   = top_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    if (!stall) begin
      if (ret_en && !ras_empty) begin
        pc_d = ras_mem[top_q];
        if (call_en) begin
          // Coroutine swap: the popped slot is reused for the new return address.
          wr_en  = 1'b1;
          wr_idx = top_q;
        end else begin
          top_d   = top_dec;
          depth_d = depth_q - DW'(1);
        end
      end else begin
        if (ret_en) begin
          unf_d = 1'b1;
        end
        if (call_en) begin
          pc_d   = branch_target;
          wr_en  = 1'b1;
          wr_idx = top_inc;
          top_d  = top_inc;
          if (ras_full) begin
            ovf_d = 1'b1;
          end else begin
            depth_d = depth_q + DW'(1);
          end
        end else if (branch_en) begin
          pc_d = branch_target;
        end else begin
          pc_d = seq_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      ras_mem[wr_idx] <= seq_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_q   <= LAST;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign ras_depth = depth_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

`else

  logic unused_ret;
  assign unused_ret = ret_en;

  // Without a stack, a call is an ordinary redirect.
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      if (call_en || branch_en) begin
        pc_d = branch_target;
      end else begin
        pc_d = seq_pc;
      end
    end
  end

  assign ras_depth = '0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;

`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized bench for pc_unit; a queue-based reference model
// tracks the INC=1 instance, the INC=2 instance covers reset vector and wrap.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_en = 1'b0;
  logic [11:0] branch_target = '0;
  logic        call_en = 1'b0;
  logic        ret_en = 1'b0;

  logic [11:0] pc_a;
  logic [2:0]  depth_a;
  logic        ovf_a;
  logic        unf_a;
  logic [11:0] pc_b;
  logic [2:0]  depth_b;
  logic        ovf_b;
  logic        unf_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model for dut_b (RESET_ADDR=0, INC=1, RAS_DEPTH=4).
  logic [11:0] m_pc;
  logic [11:0] m_ras[$];
  logic        m_ovf;
  logic        m_unf;

  always #5 clk = ~clk;

  pc_unit #(.ADDR_WIDTH(12), .RESET_ADDR(12'hFFC), .INC(2), .RAS_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .call_en(call_en), .ret_en(ret_en),
    .pc_out(pc_a), .ras_depth(depth_a), .ras_ovf(ovf_a), .ras_unf(unf_a)
  );

  pc_unit #(.ADDR_WIDTH(12), .RESET_ADDR(0), .INC(1), .RAS_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .branch_en(branch_en),
    .branch_target(branch_target), .call_en(call_en), .ret_en(ret_en),
    .pc_out(pc_b), .ras_depth(depth_b), .ras_ovf(ovf_b), .ras_unf(unf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc  = 12'h000;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic [11:0] t,
                            input logic c, input logic r);
    logic [11:0] top;
    if (s) return;
`ifdef PC_RAS_EN
    if (r && m_ras.size() > 0) begin
      top = m_ras.pop_back();
      if (c) m_ras.push_back(m_pc + 12'd1);
      m_pc = top;
    end else begin
      if (r) m_unf = 1'b1;
      if (c) begin
        if (m_ras.size() == 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_ras.push_back(m_pc + 12'd1);
        m_pc = t;
      end else if (b) begin
        m_pc = t;
      end else begin
        m_pc = m_pc + 12'd1;
      end
    end
`else
    top = t;
    if (c || b) m_pc = top;
    else m_pc = m_pc + 12'd1;
`endif
  endtask

  task automatic check_model();
    check("pc_b", pc_b, m_pc);
    check("depth_b", depth_b, m_ras.size());
    check("ovf_b", ovf_b, m_ovf);
    check("unf_b", unf_b, m_unf);
  endtask

  task automatic step(input logic s, input logic b, input logic [11:0] t,
                      input logic c, input logic r);
    stall = s; branch_en = b; branch_target = t; call_en = c; ret_en = r;
    @(posedge clk);
    model_edge(s, b, t, c, r);
    #1;
    check_model();
  endtask

  initial begin
    logic [11:0] wrap_exp [3];
    logic [11:0] addr_a   [5];
    wrap_exp = '{12'hFFE, 12'h000, 12'h002};
    model_reset();

    // Reset state and release
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc_a", pc_a, 12'hFFC);
    check_model();
    #1 reset = 1'b1;

    // Sequential advance with wrap on the INC=2 instance
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 12'h000, 0, 0);
      check("wrap_pc_a", pc_a, wrap_exp[i]);
    end

    // Asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("async_rst_pc_a", pc_a, 12'hFFC);
    check_model();
    #1 reset = 1'b1;

    // Stall beats branch
    step(0, 1, 12'h010, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 12'h200, 0, 0);
      check("stall_hold", pc_b, 12'h010);
    end
    step(0, 1, 12'h200, 0, 0);
    check("stall_release", pc_b, 12'h200);

    // Call and return
    step(0, 1, 12'h020, 0, 0);
    step(0, 0, 12'h100, 1, 0);
    check("call_pc", pc_b, 12'h100);
`ifdef PC_RAS_EN
    check("call_depth", depth_b, 3'd1);
`else
    check("call_depth", depth_b, 3'd0);
`endif
    step(0, 0, 12'h000, 0, 0);
    step(0, 0, 12'h000, 0, 0);
    step(0, 0, 12'h000, 0, 1);
`ifdef PC_RAS_EN
    check("ret_pc", pc_b, 12'h021);
    check("ret_depth", depth_b, 3'd0);
    check("ret_flags", {ovf_b, unf_b}, 2'b00);

    // Overflow: five calls into a four-entry stack
    for (int i = 0; i < 5; i++) begin
      addr_a[i] = 12'h040 + 12'(16 * i);
      step(0, 1, addr_a[i], 0, 0);
      step(0, 0, 12'h500, 1, 0);
    end
    check("ovf_depth", depth_b, 3'd4);
    check("ovf_flag", ovf_b, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 12'h000, 0, 1);
      check("ovf_ret_pc", pc_b, addr_a[4 - k] + 12'd1);
    end
    step(0, 0, 12'h000, 0, 1);
    check("unf_flag", unf_b, 1'b1);
    check("unf_seq_pc", pc_b, addr_a[1] + 12'd2);

    // Coroutine swap
    step(0, 1, 12'h020, 0, 0);
    step(0, 0, 12'h100, 1, 0);
    step(0, 1, 12'h300, 0, 0);
    step(0, 0, 12'h7AA, 1, 1);
    check("swap_pc", pc_b, 12'h021);
    check("swap_depth", depth_b, 3'd1);
    step(0, 0, 12'h000, 0, 1);
    check("swap_top", pc_b, 12'h301);
`else
    check("ret_ignored_pc", pc_b, 12'h103);
    check("ret_ignored_depth", depth_b, 3'd0);
`endif

    // Randomized control mix against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           12'($urandom_range(0, 4095)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program counter for the instruction-fetch stage, successor to the fixed 12-bit increment-only counter. It adds a configurable reset vector and step size, a fetch stall, taken-branch redirect and an optional return-address stack (RAS) for call/return. It sits between the fetch controller and instruction memory, and drives the fetch address every cycle.

## Interface
- ADDR_WIDTH, 12, PC and address width in bits.
- RESET_ADDR, 0, PC value loaded on reset; truncated to ADDR_WIDTH.
- INC, 1, sequential step added each advancing cycle.
- RAS_DEPTH, 4, return-address stack entries (≥2); used only when PC_RAS_EN is defined.
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold the PC and RAS this cycle.
- branch_en  input  1  redirect the PC to branch_target.
- branch_target  input  ADDR_WIDTH  redirect/call destination.
- call_en  input  1  push the return address and jump to branch_target.
- ret_en  input  1  pop the RAS and jump to the popped address.
- pc_out  output  ADDR_WIDTH  registered current fetch address.
- ras_depth  output  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_ovf  output  1  sticky flag: a push occurred while the RAS was full.
- ras_unf  output  1  sticky flag: a pop occurred while the RAS was empty.

## Operation
- Reset (reset low, asynchronous): pc_out=RESET_ADDR, ras_depth=0, ras_ovf=0, ras_unf=0. RAS contents are don't-care.
- Per-edge priority: stall > ret_en > call_en > branch_en > sequential.
- stall=1: PC, RAS, ras_depth and flags all hold. Every other control input is ignored for that cycle.
- Sequential: pc_out ← pc_out+INC, modulo 2^ADDR_WIDTH. Wrap-around is silent.
- branch_en: pc_out ← branch_target.
- call_en:
  - Push ret_addr = pc_out+INC (mod 2^ADDR_WIDTH), then pc_out ← branch_target. branch_en is ignored.
  - If the RAS is full: overwrite the oldest entry (circular), keep depth = RAS_DEPTH, set ras_ovf.
- ret_en with depth>0: pc_out ← top entry; depth decrements.
- ret_en with depth=0: set ras_unf, then take the next-lower-priority action. That is call, else branch, else sequential.
- ret_en and call_en together, depth>0:
  - pc_out ← top entry.
  - The top entry is replaced by pc_out+INC; depth is unchanged (coroutine swap).
  - With depth=0 this behaves as the ret-underflow case above, i.e. the call is performed.
- The flags clear only on reset.

## Timing
- Single-cycle: a control input sampled at edge N determines pc_out after edge N. There is no combinational path from any input to pc_out.
- ras_depth, ras_ovf and ras_unf update on the same edge as the PC action that causes them.
- Deassertion of reset is used directly. Integrators synchronise it upstream.
- Reset asserted mid-call/ret: the operation is abandoned and all outputs take reset values immediately.
- The first advance occurs on the first rising edge after reset deasserts with stall=0.

## Configuration
- PC_RAS_EN defined: RAS, call/ret behaviour, ras_depth and the flags are built as described.
- PC_RAS_EN undefined:
  - No RAS storage. call_en behaves exactly as branch_en. ret_en is ignored.
  - ras_depth, ras_ovf and ras_unf are tied to 0.
  - Stall and branch priority are unchanged.

## Test plan
- Reset/sequential: ADDR_WIDTH=12, RESET_ADDR=0xFFC, INC=2. Release reset, run 3 edges → pc_out 0xFFC, 0xFFE, 0x000, 0x002 (wrap). Assert reset asynchronously mid-cycle → pc_out=0xFFC before the next edge.
- Stall priority: at pc=0x010, stall=1 with branch_en=1, target=0x200, for 2 cycles → pc holds 0x010. Release stall with branch still high → pc=0x200.
- Call/return: at pc=0x020 (INC=1), call to 0x100 → pc=0x100, depth=1. Two sequential edges, then ret → pc=0x021, depth=0, flags 0.
- Overflow: RAS_DEPTH=4, five calls from pcs A..E → depth=4, ras_ovf=1. Four rets return E+1, D+1, C+1, B+1; a fifth ret → ras_unf=1 and pc advances sequentially.
- Swap: depth=1 with top=0x021, at pc=0x300 assert call_en+ret_en → pc=0x021, top=0x301, depth=1.
- PC_RAS_EN undefined: call to 0x100 → pc=0x100, ras_depth=0. ret_en alone → sequential increment.
